// File: rtl/ps2_kbd_tx.sv
// ============================================================================
// Module   : ps2_kbd_tx
// Brief    : PS/2 device-side serializer with byte FIFO; optional host-inhibit
//            support when PS2_INHIBIT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_kbd_tx #(
  parameter int HALF       = 2400,
  parameter int GAP        = 4800,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  input  logic       ps2_clk_in,
  output logic       ps2_clk,
  output logic       ps2_dat
);

  localparam int c_DEPTH = 2 ** DEPTH_LOG2;
  localparam int c_CMAX  = (HALF > GAP) ? HALF : GAP;
  localparam int c_CW    = $clog2(c_CMAX);
  localparam logic [c_CW-1:0]     c_HALF_M1  = c_CW'(HALF - 1);
  localparam logic [c_CW-1:0]     c_GAP_M1   = c_CW'(GAP - 1);
  localparam logic [3:0]          c_LAST_BIT = 4'd10;
  localparam logic [DEPTH_LOG2:0] c_FULL_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BIT_HI = 3'd1,
    S_BIT_LO = 3'd2,
    S_GAP    = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_CW-1:0]       r_cnt, w_cnt_nxt;
  logic [3:0]            r_idx, w_idx_nxt;
  logic [10:0]           r_shift, w_shift_nxt;
  logic                  r_ps2_clk, w_clk_nxt;
  logic                  r_ps2_dat, w_dat_nxt;
  logic                  r_overflow;
  logic                  w_pop, w_push, w_full, w_inhibit;
  logic [7:0]            r_mem [c_DEPTH];
  logic [7:0]            w_head;
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  assign w_full = (r_count == c_FULL_CNT);
  assign w_push = wr & ~w_full;
  assign w_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // The head stays in the FIFO for its whole frame; it is popped only after the stop bit.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr & w_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PS2_INHIBIT_EN
  logic [1:0] r_clk_sync;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
    end
  end

  assign w_inhibit = ~r_clk_sync[1] & r_ps2_clk;
`else
  // Sensed clock line is ignored when inhibit support is compiled out.
  assign w_inhibit = ps2_clk_in & 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_clk_nxt   = 1'b1;
    w_dat_nxt   = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          if (w_inhibit) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = c_GAP_M1;
          end else begin
            w_state_nxt = S_BIT_HI;
            w_cnt_nxt   = c_HALF_M1;
            w_idx_nxt   = 4'd0;
            w_shift_nxt = {1'b1, ~^w_head, w_head, 1'b0};
            w_dat_nxt   = 1'b0;
          end
        end
      end
      S_BIT_HI: begin
        w_dat_nxt = r_shift[r_idx];
        if (w_inhibit && (r_idx != c_LAST_BIT)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_GAP_M1;
          w_dat_nxt   = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_BIT_LO;
          w_cnt_nxt   = c_HALF_M1;
          w_clk_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_BIT_LO: begin
        w_clk_nxt = 1'b0;
        w_dat_nxt = r_shift[r_idx];
        if (r_cnt == '0) begin
          w_clk_nxt = 1'b1;
          if (r_idx == c_LAST_BIT) begin
            w_pop       = 1'b1;
            w_state_nxt = S_GAP;
            w_cnt_nxt   = c_GAP_M1;
            w_dat_nxt   = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = S_BIT_HI;
            w_cnt_nxt   = c_HALF_M1;
            w_dat_nxt   = r_shift[r_idx + 4'd1];
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (w_inhibit) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_GAP_M1;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        // Any inhibit cycle restarts the quiet-period count.
        if (w_inhibit) begin
          w_cnt_nxt = c_GAP_M1;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '1;
      r_ps2_clk <= 1'b1;
      r_ps2_dat <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_ps2_clk <= w_clk_nxt;
      r_ps2_dat <= w_dat_nxt;
    end
  end

  assign full     = w_full;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) | (r_count != '0);
  assign ps2_clk  = r_ps2_clk;
  assign ps2_dat  = r_ps2_dat;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_tx.sv
// ============================================================================
// Module   : tb_ps2_kbd_tx
// Brief    : Self-checking bench for ps2_kbd_tx; decodes frames off the lines.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_kbd_tx;

  localparam int HALF       = 4;
  localparam int GAP        = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic       clk_sys = 1'b0;
  logic       reset, wr, ps2_clk_in;
  logic [7:0] din;
  logic       full, overflow, busy, ps2_clk, ps2_dat;

  int checks = 0, errors = 0;
  int cyc = 0, edges = 0, frames_done = 0, aborts = 0, ovf_pulses = 0;
  int bits_seen = 0, hi_run = 0, first_t = 0, last_t = 0;
  bit have_last = 1'b0;
  logic prev_clk = 1'b1;
  logic [10:0] cur = '0, last_frame = '0;
  logic [7:0]  expq[$];

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_tx #(.HALF(HALF), .GAP(GAP), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .din       (din),
    .wr        (wr),
    .full      (full),
    .overflow  (overflow),
    .busy      (busy),
    .ps2_clk_in(ps2_clk_in),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as a PS/2 device should send it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += b[i] ? 1 : 0;
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  always @(negedge clk_sys) begin
    cyc++;
    if (reset) begin
      bits_seen = 0;
      hi_run    = 0;
      have_last = 1'b0;
    end else begin
      if (prev_clk && !ps2_clk) begin
        edges++;
        if (bits_seen == 0) begin
          first_t = cyc;
          if (have_last) check("frame_spacing", 32'(cyc - last_t >= 2*HALF + GAP + 1), 1);
        end
        cur[bits_seen] = ps2_dat;
        bits_seen++;
        if (bits_seen == 11) begin
          check("frame_length", cyc - first_t, 20*HALF);
          last_frame = cur;
          check("frame_expected", 32'(expq.size() > 0), 1);
          if (expq.size() > 0) check("frame_bits", 32'(cur), 32'(exp_frame(expq.pop_front())));
          last_t    = cyc;
          have_last = 1'b1;
          bits_seen = 0;
          frames_done++;
        end
      end
      hi_run = ps2_clk ? hi_run + 1 : 0;
      if (hi_run > HALF + 1 && bits_seen != 0) begin
        aborts++;
        bits_seen = 0;
      end
      if (overflow) ovf_pulses++;
    end
    prev_clk = ps2_clk;
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic do_write(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    if (expq.size() < DEPTH) expq.push_back(b);
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int t = 0;
    while (frames_done < n && t < budget) begin
      tick();
      t++;
    end
    check(tag, 32'(frames_done >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      tick();
      t++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int ovf0, f0, e0, a0, rel_t, n;
    reset = 1'b1; wr = 1'b0; din = '0; ps2_clk_in = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_clk", ps2_clk, 1);
    check("reset_dat", ps2_dat, 1);
    check("reset_full", full, 0);
    check("reset_overflow", overflow, 0);
    check("reset_busy", busy, 0);

    do_write(8'h1C);
    wait_frames(1, 200, "frame_1c_done");
    check("frame_1c_bits", 32'(last_frame), 32'(11'b10000111000));
    check("frame_1c_edges", edges, 11);
    repeat (11) tick();
    check("busy_in_gap", busy, 1);
    tick();
    check("busy_after_gap", busy, 0);

    do_write(8'h00);
    do_write(8'hFF);
    wait_frames(2, 400, "frame_00_done");
    check("frame_00_bits", 32'(last_frame), 32'(11'b11000000000));
    wait_frames(3, 400, "frame_ff_done");
    check("frame_ff_bits", 32'(last_frame), 32'(11'b11111111110));
    wait_idle(100);

    ovf0 = ovf_pulses;
    f0   = frames_done;
    for (int i = 0; i < 17; i++) begin
      b   = 8'($urandom);
      din = b;
      wr  = 1'b1;
      if (i == 15) check("not_full_at_15", full, 0);
      if (i == 16) check("full_at_16", full, 1);
      if (expq.size() < DEPTH) expq.push_back(b);
      tick();
    end
    wr = 1'b0;
    tick();
    tick();
    check("overflow_pulses", ovf_pulses - ovf0, 1);
    wait_frames(f0 + 16, 3000, "burst_frames");
    check("burst_queue_drained", expq.size(), 0);
    wait_idle(100);

    do_write(8'h5A);
    repeat (29) tick();
    reset = 1'b1;
    tick();
    check("midreset_clk", ps2_clk, 1);
    check("midreset_dat", ps2_dat, 1);
    check("midreset_busy", busy, 0);
    reset = 1'b0;
    expq.delete();
    e0 = edges;
    repeat (200) tick();
    check("no_edges_after_reset", edges, e0);
    check("idle_after_reset", busy, 0);

    for (int r = 0; r < 4; r++) begin
      f0 = frames_done;
      n  = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        do_write(8'($urandom));
        repeat ($urandom_range(0, 40)) tick();
      end
      wait_frames(f0 + n, 1000, "random_frames");
      wait_idle(100);
    end
    check("final_queue_empty", expq.size(), 0);

`ifdef PS2_INHIBIT_EN
    f0 = frames_done;
    a0 = aborts;
    do_write(8'h29);
    n = 0;
    while (bits_seen < 4 && n < 300) begin
      tick();
      n++;
    end
    check("inh_reached_bit4", bits_seen, 4);
    repeat (4) tick();
    ps2_clk_in = 1'b0;
    repeat (6) tick();
    check("inh_abort_clk", ps2_clk, 1);
    check("inh_abort_dat", ps2_dat, 1);
    check("inh_abort_busy", busy, 1);
    repeat (4) tick();
    ps2_clk_in = 1'b1;
    rel_t = cyc;
    wait_frames(f0 + 1, 400, "inh_retransmit");
    check("inh_abort_seen", aborts - a0, 1);
    check("inh_restart_delay", 32'(first_t - rel_t >= GAP), 1);
    wait_idle(100);

    ps2_clk_in = 1'b0;
    e0 = edges;
    f0 = frames_done;
    do_write(8'h3D);
    repeat (50) tick();
    check("inh_no_edges", edges, e0);
    check("inh_busy_pending", busy, 1);
    ps2_clk_in = 1'b1;
    rel_t = cyc;
    wait_frames(f0 + 1, 400, "inh_prewrite_frame");
    check("inh_prewrite_delay", 32'(first_t - rel_t >= GAP), 1);
    wait_idle(100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
